// File: rtl/sccb_init_seq.sv
`default_nettype none
// ============================================================================
// sccb_init_seq : table-driven write / read-verify / delay sequencer for sccb_fsm
// Revision      : 1.0
// ============================================================================
module sccb_init_seq #(
  parameter int DATA_W  = 8,
  parameter int IDX_W   = 8,
  parameter int DLY_CYC = 1000
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                start_i,
  output logic                busy_o,
  output logic                done_o,
  output logic                err_o,
  output logic [IDX_W-1:0]    err_idx_o,
  output logic [IDX_W-1:0]    tbl_addr_o,
  input  logic [2*DATA_W+1:0] tbl_data_i,
  input  logic                sccb_busy_i,
  output logic                ctrl_vld_o,
  input  logic                ctrl_rdy_i,
  output logic                trans_type_o,
  output logic [1:0]          phase_amt_o,
  output logic [DATA_W-1:0]   tx_sub_adr_o,
  output logic                tx_sub_adr_vld_o,
  input  logic                tx_sub_adr_rdy_i,
  output logic [DATA_W-1:0]   tx_data_o,
  output logic                tx_data_vld_o,
  input  logic                tx_data_rdy_i,
  input  logic [DATA_W-1:0]   rx_data_i,
  input  logic                rx_vld_i,
  output logic                rx_rdy_o
);

  localparam int                c_UNIT_W    = (DLY_CYC > 1) ? $clog2(DLY_CYC) : 1;
  localparam logic [c_UNIT_W-1:0] c_UNIT_LAST = c_UNIT_W'(DLY_CYC - 1);
  localparam logic [IDX_W-1:0]  c_IDX_LAST  = {IDX_W{1'b1}};
  localparam logic [1:0]        c_CMD_WRITE  = 2'd0;
  localparam logic [1:0]        c_CMD_DELAY  = 2'd1;
  localparam logic [1:0]        c_CMD_END    = 2'd2;
  localparam logic [1:0]        c_CMD_VERIFY = 2'd3;

  typedef enum logic [3:0] {
    S_IDLE      = 4'd0,
    S_FETCH     = 4'd1,
    S_DECODE    = 4'd2,
    S_ISSUE     = 4'd3,
    S_WAIT_XFER = 4'd4,
    S_WAIT_RX   = 4'd5,
    S_DELAY     = 4'd6,
    S_NEXT      = 4'd7,
    S_DONE      = 4'd8
  } state_t;

  state_t              r_state,      w_state;
  logic [IDX_W-1:0]    r_idx,        w_idx;
  logic                r_verify,     w_verify;
  logic                r_rd_phase,   w_rd_phase;
  logic                r_first,      w_first;
  logic                r_got_rx,     w_got_rx;
  logic                r_mis,        w_mis;
  logic                r_err,        w_err;
  logic [IDX_W-1:0]    r_err_idx,    w_err_idx;
  logic [DATA_W-1:0]   r_exp,        w_exp;
  logic                r_trans_type, w_trans_type;
  logic [1:0]          r_phase_amt,  w_phase_amt;
  logic [DATA_W-1:0]   r_tx_sub_adr, w_tx_sub_adr;
  logic [DATA_W-1:0]   r_tx_data,    w_tx_data;
  logic                r_sub_vld,    w_sub_vld;
  logic                r_data_vld,   w_data_vld;
  logic [c_UNIT_W-1:0] r_unit,       w_unit;
  logic [DATA_W-1:0]   r_cnt,        w_cnt;

  logic [1:0]          w_tbl_cmd;
  logic [DATA_W-1:0]   w_tbl_sub;
  logic [DATA_W-1:0]   w_tbl_data;

  assign w_tbl_cmd  = tbl_data_i[2*DATA_W +: 2];
  assign w_tbl_sub  = tbl_data_i[DATA_W +: DATA_W];
  assign w_tbl_data = tbl_data_i[0 +: DATA_W];

  always_comb begin
    w_state      = r_state;
    w_idx        = r_idx;
    w_verify     = r_verify;
    w_rd_phase   = r_rd_phase;
    w_first      = r_first;
    w_got_rx     = r_got_rx;
    w_mis        = r_mis;
    w_err        = r_err;
    w_err_idx    = r_err_idx;
    w_exp        = r_exp;
    w_trans_type = r_trans_type;
    w_phase_amt  = r_phase_amt;
    w_tx_sub_adr = r_tx_sub_adr;
    w_tx_data    = r_tx_data;
    w_sub_vld    = r_sub_vld;
    w_data_vld   = r_data_vld;
    w_unit       = r_unit;
    w_cnt        = r_cnt;

    // TX streams complete independently of the control handshake.
    if (r_sub_vld && tx_sub_adr_rdy_i) w_sub_vld = 1'b0;
    if (r_data_vld && tx_data_rdy_i)   w_data_vld = 1'b0;

    case (r_state)
      S_IDLE: begin
        if (start_i) begin
          w_err   = 1'b0;
          w_idx   = '0;
          w_state = S_FETCH;
        end
      end

      S_FETCH: w_state = S_DECODE;

      S_DECODE: begin
        case (w_tbl_cmd)
          c_CMD_WRITE: begin
            w_verify     = 1'b0;
            w_rd_phase   = 1'b0;
            w_trans_type = 1'b1;
            w_phase_amt  = 2'd3;
            w_tx_sub_adr = w_tbl_sub;
            w_tx_data    = w_tbl_data;
            w_sub_vld    = 1'b1;
            w_data_vld   = 1'b1;
            w_state      = S_ISSUE;
          end
          c_CMD_VERIFY: begin
            w_verify     = 1'b1;
            w_rd_phase   = 1'b0;
            w_exp        = w_tbl_data;
            w_trans_type = 1'b1;
            w_phase_amt  = 2'd2;
            w_tx_sub_adr = w_tbl_sub;
            w_sub_vld    = 1'b1;
            w_data_vld   = 1'b0;
            w_state      = S_ISSUE;
          end
          c_CMD_DELAY: begin
            w_unit  = '0;
            w_cnt   = w_tbl_data;
            w_state = S_DELAY;
          end
          default: w_state = S_DONE;
        endcase
      end

      S_ISSUE: begin
        if (ctrl_rdy_i) begin
          w_first = 1'b1;
          if (r_verify && r_rd_phase) begin
            w_got_rx = 1'b0;
            w_mis    = 1'b0;
            w_state  = S_WAIT_RX;
          end else begin
            w_state  = S_WAIT_XFER;
          end
        end
      end

      S_WAIT_XFER: begin
        // sccb_fsm busy lags the handshake by one cycle, so skip that cycle.
        if (r_first) begin
          w_first = 1'b0;
        end else if (!sccb_busy_i) begin
          if (r_verify) begin
            w_rd_phase   = 1'b1;
            w_trans_type = 1'b0;
            w_phase_amt  = 2'd2;
            w_state      = S_ISSUE;
          end else begin
            w_state = S_NEXT;
          end
        end
      end

      S_WAIT_RX: begin
        if (!r_got_rx) begin
          if (rx_vld_i) begin
            w_got_rx = 1'b1;
            w_mis    = (rx_data_i != r_exp);
          end
        end else if (!sccb_busy_i) begin
          if (r_mis) begin
            w_err     = 1'b1;
            w_err_idx = r_idx;
            w_state   = S_DONE;
          end else begin
            w_state = S_NEXT;
          end
        end
      end

      S_DELAY: begin
        if (r_cnt == '0) begin
          w_state = S_NEXT;
        end else if (r_unit == c_UNIT_LAST) begin
          w_unit = '0;
          w_cnt  = r_cnt - DATA_W'(1);
          if (r_cnt == DATA_W'(1)) w_state = S_NEXT;
        end else begin
          w_unit = r_unit + c_UNIT_W'(1);
        end
      end

      S_NEXT: begin
        if (r_idx == c_IDX_LAST) begin
          w_state = S_DONE;
        end else begin
          w_idx   = r_idx + IDX_W'(1);
          w_state = S_FETCH;
        end
      end

      S_DONE: w_state = S_IDLE;

      default: w_state = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state      <= S_IDLE;
      r_idx        <= '0;
      r_verify     <= 1'b0;
      r_rd_phase   <= 1'b0;
      r_first      <= 1'b0;
      r_got_rx     <= 1'b0;
      r_mis        <= 1'b0;
      r_err        <= 1'b0;
      r_err_idx    <= '0;
      r_exp        <= '0;
      r_trans_type <= 1'b1;
      r_phase_amt  <= 2'd3;
      r_tx_sub_adr <= '0;
      r_tx_data    <= '0;
      r_sub_vld    <= 1'b0;
      r_data_vld   <= 1'b0;
      r_unit       <= '0;
      r_cnt        <= '0;
    end else begin
      r_state      <= w_state;
      r_idx        <= w_idx;
      r_verify     <= w_verify;
      r_rd_phase   <= w_rd_phase;
      r_first      <= w_first;
      r_got_rx     <= w_got_rx;
      r_mis        <= w_mis;
      r_err        <= w_err;
      r_err_idx    <= w_err_idx;
      r_exp        <= w_exp;
      r_trans_type <= w_trans_type;
      r_phase_amt  <= w_phase_amt;
      r_tx_sub_adr <= w_tx_sub_adr;
      r_tx_data    <= w_tx_data;
      r_sub_vld    <= w_sub_vld;
      r_data_vld   <= w_data_vld;
      r_unit       <= w_unit;
      r_cnt        <= w_cnt;
    end
  end

  assign busy_o           = (r_state != S_IDLE) && (r_state != S_DONE);
  assign done_o           = (r_state == S_DONE);
  assign err_o            = r_err;
  assign err_idx_o        = r_err_idx;
  assign tbl_addr_o       = r_idx;
  assign ctrl_vld_o       = (r_state == S_ISSUE);
  assign trans_type_o     = r_trans_type;
  assign phase_amt_o      = r_phase_amt;
  assign tx_sub_adr_o     = r_tx_sub_adr;
  assign tx_sub_adr_vld_o = r_sub_vld;
  assign tx_data_o        = r_tx_data;
  assign tx_data_vld_o    = r_data_vld;
  assign rx_rdy_o         = (r_state == S_WAIT_RX) && !r_got_rx;

endmodule
`default_nettype wire

// File: tb/tb_sccb_init_seq.sv
`default_nettype none
// tb_sccb_init_seq : scoreboard bench with a table-walking reference model
// and a randomised sccb_fsm responder.
module tb_sccb_init_seq;
  localparam int DATA_W  = 8;
  localparam int IDX_W   = 8;
  localparam int DLY_CYC = 4;
  localparam int DEPTH   = 256;
  localparam logic [1:0] CW = 2'd0, CD = 2'd1, CE = 2'd2, CV = 2'd3;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic        busy, done, err;
  logic [7:0]  err_idx, tbl_addr;
  logic [17:0] tbl_data = '0;
  logic        sccb_busy, ctrl_vld, ctrl_rdy, trans_type;
  logic [1:0]  phase_amt;
  logic [7:0]  tx_sub_adr, tx_data, rx_data;
  logic        tx_sub_vld, tx_sub_rdy, tx_data_vld, tx_data_rdy, rx_vld, rx_rdy;

  always #5 clk = ~clk;

  sccb_init_seq #(.DATA_W(DATA_W), .IDX_W(IDX_W), .DLY_CYC(DLY_CYC)) dut (
    .clk(clk), .rst(rst), .start_i(start), .busy_o(busy), .done_o(done),
    .err_o(err), .err_idx_o(err_idx), .tbl_addr_o(tbl_addr), .tbl_data_i(tbl_data),
    .sccb_busy_i(sccb_busy), .ctrl_vld_o(ctrl_vld), .ctrl_rdy_i(ctrl_rdy),
    .trans_type_o(trans_type), .phase_amt_o(phase_amt),
    .tx_sub_adr_o(tx_sub_adr), .tx_sub_adr_vld_o(tx_sub_vld), .tx_sub_adr_rdy_i(tx_sub_rdy),
    .tx_data_o(tx_data), .tx_data_vld_o(tx_data_vld), .tx_data_rdy_i(tx_data_rdy),
    .rx_data_i(rx_data), .rx_vld_i(rx_vld), .rx_rdy_o(rx_rdy)
  );

  // Synchronous table ROM: data follows the address by one clock.
  logic [17:0] tbl [DEPTH];
  always @(posedge clk) tbl_data <= tbl[tbl_addr];

  typedef struct {
    int         kind;      // 0 write, 1 verify addr, 2 verify read, 3 done
    logic [7:0] sub;
    logic [7:0] data;
    logic       err;
    logic [7:0] eidx;
    logic [7:0] last_idx;
    int         lat;       // start-to-done cycles, -1 when not predictable
  } exp_t;

  exp_t       exp_q[$];
  logic [7:0] rx_q[$];
  int errors = 0, checks = 0;
  int cyc = 0, start_cyc = 0, done_cnt = 0;
  logic       hold = 1'b0;
  logic [7:0] hold_idx = 8'd0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got 0x%0h required 0x%0h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  function automatic logic [17:0] mk(input logic [1:0] c, input logic [7:0] s, input logic [7:0] d);
    return {c, s, d};
  endfunction

  task automatic clear_tbl();
    for (int i = 0; i < DEPTH; i++) tbl[i] = mk(CE, 8'h00, 8'h00);
  endtask

  // Reference model: walk the table by its command rules and queue every
  // transaction and the final outcome the sequencer must produce.
  task automatic model_run(input int mis_pct);
    int   lat;
    bit   ctrl;
    exp_t e;
    logic [7:0] resp;
    lat  = 2;
    ctrl = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      logic [1:0] c;
      logic [7:0] s, d;
      {c, s, d} = tbl[i];
      e = '{kind: 0, sub: s, data: d, err: 1'b0, eidx: 8'd0, last_idx: 8'(i), lat: -1};
      if (c == CE) begin
        e.kind = 3;
        e.lat  = ctrl ? -1 : lat;
        exp_q.push_back(e);
        return;
      end else if (c == CW) begin
        ctrl = 1'b1;
        exp_q.push_back(e);
      end else if (c == CD) begin
        lat += 3 + ((d == 8'd0) ? 1 : int'(d) * DLY_CYC);
      end else begin
        ctrl = 1'b1;
        e.kind = 1; exp_q.push_back(e);
        e.kind = 2; exp_q.push_back(e);
        resp = ($urandom_range(0, 99) < mis_pct) ? (d ^ 8'($urandom_range(1, 255))) : d;
        rx_q.push_back(resp);
        if (resp != d) begin
          e.kind = 3; e.err = 1'b1; e.eidx = 8'(i);
          exp_q.push_back(e);
          return;
        end
      end
    end
    e = '{kind: 3, sub: 8'd0, data: 8'd0, err: 1'b0, eidx: 8'd0, last_idx: 8'hFF, lat: -1};
    exp_q.push_back(e);
  endtask

  // sccb_fsm responder: accepts control, consumes tx bytes, returns rx data.
  initial begin : slave
    int s_st, s_cnt;
    bit need_sub, need_data, need_rx, rx_hs;
    logic s_tt;
    logic [1:0] s_ph;
    s_st = 0; s_cnt = 0; rx_hs = 0; need_sub = 0; need_data = 0; need_rx = 0;
    s_tt = 1'b1; s_ph = 2'd3;
    ctrl_rdy = 0; sccb_busy = 0; tx_sub_rdy = 0; tx_data_rdy = 0; rx_vld = 0; rx_data = 0;
    forever begin
      @(posedge clk); #1;
      if (rst) begin
        ctrl_rdy = 0; sccb_busy = 0; tx_sub_rdy = 0; tx_data_rdy = 0; rx_vld = 0;
        s_st = 0; s_cnt = 0; rx_hs = 0;
      end else begin
        case (s_st)
          0: begin
            ctrl_rdy = 0;
            if (ctrl_vld && !(hold && tbl_addr == hold_idx)) begin
              if (s_cnt > 0) s_cnt--;
              else begin ctrl_rdy = 1; s_tt = trans_type; s_ph = phase_amt; s_st = 1; end
            end
          end
          1: begin
            ctrl_rdy  = 0;
            sccb_busy = 1;
            need_sub  = s_tt;
            need_data = s_tt && (s_ph == 2'd3);
            need_rx   = !s_tt;
            s_cnt     = $urandom_range(0, 3);
            s_st      = 2;
          end
          default: begin
            if (tx_sub_rdy) begin tx_sub_rdy = 0; need_sub = 0; s_cnt = $urandom_range(0, 2); end
            else if (tx_data_rdy) begin tx_data_rdy = 0; need_data = 0; s_cnt = $urandom_range(0, 2); end
            else if (rx_vld && rx_hs) begin rx_vld = 0; need_rx = 0; s_cnt = $urandom_range(0, 2); end
            else if (s_cnt > 0) s_cnt--;
            else if (need_sub) begin if (tx_sub_vld) tx_sub_rdy = 1; end
            else if (need_data) begin if (tx_data_vld) tx_data_rdy = 1; end
            else if (need_rx) begin
              if (!rx_vld) begin
                rx_vld  = 1;
                rx_data = (rx_q.size() > 0) ? rx_q.pop_front() : 8'h00;
              end
            end else begin
              sccb_busy = 0; s_st = 0; s_cnt = $urandom_range(0, 3);
            end
            rx_hs = rx_vld && rx_rdy;
          end
        endcase
      end
    end
  end

  // Monitor: pops the scoreboard on every control handshake and done pulse.
  initial begin : monitor
    exp_t e;
    int   act_kind;
    forever begin
      @(negedge clk);
      if (!rst) begin
        if (ctrl_vld && ctrl_rdy) begin
          if (exp_q.size() == 0) begin
            checks++; errors++;
            $display("FAIL unexpected_ctrl: got type=%0d phase=%0d required none", trans_type, phase_amt);
          end else begin
            e = exp_q.pop_front();
            act_kind = trans_type ? ((phase_amt == 2'd3) ? 0 : 1) : ((phase_amt == 2'd2) ? 2 : 9);
            check("ctrl_kind", act_kind, e.kind);
            check("tx_sub_vld", tx_sub_vld, e.kind == 0 || e.kind == 1);
            check("tx_data_vld", tx_data_vld, e.kind == 0);
            if (e.kind == 0 || e.kind == 1) check("tx_sub_adr", tx_sub_adr, e.sub);
            if (e.kind == 0) check("tx_data", tx_data, e.data);
          end
        end
        if (done) begin
          done_cnt++;
          if (exp_q.size() == 0) begin
            checks++; errors++;
            $display("FAIL unexpected_done: got done=1 required 0");
          end else begin
            e = exp_q.pop_front();
            check("done_order", 3, e.kind);
            check("err", err, e.err);
            if (e.err) check("err_idx", err_idx, e.eidx);
            check("busy_at_done", busy, 0);
            check("last_idx", tbl_addr, e.last_idx);
            if (e.lat >= 0) check("latency", cyc - start_cyc, e.lat);
          end
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk); #2;
  endtask

  task automatic start_run(input int mis_pct);
    logic [1:0] c0;
    model_run(mis_pct);
    c0 = tbl[0][17:16];
    start = 1'b1;
    tick();
    start = 1'b0;
    start_cyc = cyc;
    if (c0 == CW || c0 == CV) begin
      tick();
      check("vld_before_issue", ctrl_vld, 0);
      tick();
      check("start_to_vld", ctrl_vld, 1);
    end
  endtask

  task automatic wait_done(input int pre);
    int k;
    for (k = 0; k < 20000 && done_cnt <= pre; k++) tick();
    if (done_cnt <= pre) begin
      checks++; errors++;
      $display("FAIL done_timeout: got no done after %0d cycles required done", k);
    end
    repeat (3) tick();
    check("scoreboard_drained", exp_q.size(), 0);
  endtask

  task automatic run(input int mis_pct);
    int pre;
    pre = done_cnt;
    start_run(mis_pct);
    wait_done(pre);
  endtask

  task automatic check_reset_vals();
    check("rst_busy", busy, 0);          check("rst_done", done, 0);
    check("rst_err", err, 0);            check("rst_err_idx", err_idx, 0);
    check("rst_tbl_addr", tbl_addr, 0);  check("rst_ctrl_vld", ctrl_vld, 0);
    check("rst_sub_vld", tx_sub_vld, 0); check("rst_data_vld", tx_data_vld, 0);
    check("rst_rx_rdy", rx_rdy, 0);      check("rst_type", trans_type, 1);
    check("rst_phase", phase_amt, 3);    check("rst_sub_bus", tx_sub_adr, 0);
    check("rst_data_bus", tx_data, 0);
  endtask

  initial begin : driver
    int pre, n, k;
    bit found;
    logic [1:0] c;
    logic [7:0] d;
    clear_tbl();
    repeat (3) tick();
    check_reset_vals();
    rst = 1'b0;
    tick();

    clear_tbl(); tbl[0] = mk(CW, 8'h12, 8'h80); run(0);
    clear_tbl(); tbl[0] = mk(CD, 8'h00, 8'd3);  run(0);
    clear_tbl(); tbl[0] = mk(CD, 8'h00, 8'd0);  run(0);
    clear_tbl(); tbl[0] = mk(CV, 8'h0A, 8'h76); run(0);
    clear_tbl(); tbl[0] = mk(CV, 8'h0A, 8'h76); run(100);

    for (int r = 0; r < 12; r++) begin
      clear_tbl();
      n = $urandom_range(1, 8);
      for (int i = 0; i < n; i++) begin
        k = $urandom_range(0, 2);
        c = (k == 0) ? CW : (k == 1) ? CD : CV;
        d = (c == CD) ? 8'($urandom_range(0, 3)) : 8'($urandom);
        tbl[i] = mk(c, 8'($urandom), d);
      end
      run(25);
    end

    // Stalled control handshake on the second entry, with a stray start.
    clear_tbl();
    tbl[0] = mk(CW, 8'h11, 8'h22);
    tbl[1] = mk(CW, 8'h33, 8'h44);
    hold_idx = 8'd1;
    hold = 1'b1;
    pre = done_cnt;
    start_run(0);
    found = 1'b0;
    for (int i = 0; i < 200 && !found; i++) begin
      tick();
      found = ctrl_vld && (tbl_addr == 8'd1);
    end
    check("hold_reached", found, 1);
    for (int i = 0; i < 20; i++) begin
      start = (i == 5);
      tick();
      check("hold_vld", ctrl_vld, 1);     check("hold_type", trans_type, 1);
      check("hold_phase", phase_amt, 3);  check("hold_sub", tx_sub_adr, 8'h33);
      check("hold_data", tx_data, 8'h44); check("hold_sub_vld", tx_sub_vld, 1);
      check("hold_data_vld", tx_data_vld, 1);
      check("hold_busy", busy, 1);
    end
    start = 1'b0;
    hold = 1'b0;
    wait_done(pre);

    // Full-depth table with no END entry.
    for (int i = 0; i < DEPTH; i++) tbl[i] = mk(CW, 8'($urandom), 8'($urandom));
    run(0);

    // Leave err set, then reset in the middle of the second entry.
    clear_tbl(); tbl[0] = mk(CV, 8'h05, 8'h06); run(100);
    check("err_sticky", err, 1);
    clear_tbl();
    tbl[0] = mk(CW, 8'hA1, 8'h01);
    tbl[1] = mk(CW, 8'hA2, 8'h02);
    tbl[2] = mk(CW, 8'hA3, 8'h03);
    start_run(0);
    found = 1'b0;
    for (int i = 0; i < 200 && !found; i++) begin
      tick();
      found = (tbl_addr == 8'd1);
    end
    check("rst_point_reached", found, 1);
    tick();
    rst = 1'b1;
    tick();
    check_reset_vals();
    exp_q.delete();
    rx_q.delete();
    rst = 1'b0;
    pre = done_cnt;
    repeat (10) tick();
    check("no_done_after_rst", done_cnt, pre);
    run(0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
